alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) that sits beside the single-cycle ALU in EX.
- Parametrised operand width. Uses iterative radix-2 shift-add multiply and restoring divide.
- Valid/ready handshake on input and output, so the pipeline stalls EX while the unit is busy.
- Produces alu_out/alu_zero/alu_neg with the same semantics as the single-cycle ALU.

Parameters:
- WIDTH, 32, operand/result width in bits (even, >= 8).
- TAG_W, 5, width of the opaque tag (rd index) carried from input to output.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  abort the in-flight op (branch mispredict/trap); synchronous.
- in_valid  in  1  op/bus_a/bus_b/in_tag valid.
- in_ready  out  1  unit can accept an op this cycle.
- op  in  3  md_op_e (RISC-V funct3 encoding).
- bus_a  in  WIDTH  rs1 value (dividend/multiplicand).
- bus_b  in  WIDTH  rs2 value (divisor/multiplier).
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- alu_out  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.
- alu_zero  out  1  alu_out == 0.
- alu_neg  out  1  alu_out[WIDTH-1].
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, in_ready=1, out_valid=0, busy=0, alu_out=0, out_tag=0, alu_zero=1, alu_neg=0. Reset applies mid-operation and discards any partial result.
- FSM states are IDLE, CALC, DONE.
  - IDLE -> CALC on in_valid && in_ready for non-fast-path ops.
  - IDLE -> DONE directly for fast-path ops.
  - CALC -> DONE when the iteration counter reaches WIDTH-1.
  - DONE -> IDLE on out_ready.
- in_ready = (state==IDLE). No op is accepted while in CALC or DONE.
- Latency: accept in cycle 0 -> out_valid=1 in cycle WIDTH+1 for the iterative path, or in cycle 1 for the fast path.
- out_valid, alu_out and out_tag hold stable while out_valid && !out_ready.
- Operands, op and tag are captured at acceptance; input changes afterwards are ignored.
- Multiply:
  - Take operand magnitudes per signedness: MULH signs both operands, MULHSU signs bus_a only, MULHU and MUL sign neither.
  - Form a 2*WIDTH unsigned product with one bit per cycle.
  - Negate the product if the result sign is negative.
  - MUL returns the low WIDTH bits; the MULH variants return the high WIDTH bits.
- Divide:
  - Operate on magnitudes; one quotient bit per cycle.
  - Quotient is negated if the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- Fast path cases, each with out_valid in cycle 1:
  - Divide by zero: DIV/DIVU -> all-ones; REM/REMU -> bus_a.
  - Signed overflow (bus_a = MIN, bus_b = -1): DIV -> MIN; REM -> 0.
- alu_zero and alu_neg are combinational from the registered alu_out.
- flush:
  - Forces state=IDLE and out_valid=0 at the next edge.
  - Discards the result, including one held in DONE.
  - If flush and in_valid are both high in IDLE, flush wins and nothing is accepted.
- If rst and flush are asserted together, rst governs.
- Overflowing counter/product bits are truncated to the stated widths; no wrap-around is visible externally.

Decomposition:
- Package md_pkg:
  - typedef enum logic[2:0] md_op_e: MD_MUL=0, MD_MULH=1, MD_MULHSU=2, MD_MULHU=3, MD_DIV=4, MD_DIVU=5, MD_REM=6, MD_REMU=7.
  - typedef enum md_state_e: IDLE, CALC, DONE.
  - Helper function is_div(op).
- One natural sub-module, md_signfix: combinational operand-magnitude and result-negation logic, shared by both datapaths. The FSM, counter and shift registers stay in alu_muldiv.

Test Plan (WIDTH=32):
- MUL: 7 × -3 (0xFFFFFFFD), tag 5 -> alu_out=0xFFFFFFEB in cycle 33, out_tag=5, alu_neg=1; MULHU of 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHSU -1 × 0xFFFFFFFF -> 0xFFFFFFFF. DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF (-1).
- Divide by zero: DIVU 100/0 -> 0xFFFFFFFF and REM 100/0 -> 100, both in cycle 1. DIV 0x80000000/-1 -> 0x80000000 and REM -> 0, both in cycle 1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result stable and in_ready=0 throughout. Raise out_ready -> in_ready=1 in the next cycle.
- Flush in cycle 10 of a DIV -> out_valid never asserted and in_ready=1 next cycle; a new MUL accepted then completes correctly.
- rst asserted mid-CALC -> next edge: out_valid=0, alu_out=0, alu_zero=1, in_ready=1.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types for the RV32M multiply/divide execute unit.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

  function automatic logic is_div(input md_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/md_signfix.sv
// Operand magnitude extraction and result sign correction shared by the
// multiply and divide datapaths.
module md_signfix
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  md_op_e             op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   a_mag,
  output logic [WIDTH-1:0]   b_mag,
  output logic               res_neg,
  input  md_op_e             res_op,
  input  logic               res_neg_q,
  input  logic [2*WIDTH-1:0] raw,
  output logic [WIDTH-1:0]   res
);

  logic               sa;
  logic               sb;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   div_v;
  logic [WIDTH-1:0]   div_s;

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    case (op)
      MD_MULH, MD_DIV, MD_REM: begin
        sa = a[WIDTH-1];
        sb = b[WIDTH-1];
      end
      MD_MULHSU: sa = a[WIDTH-1];
      default: ;
    endcase
    a_mag   = sa ? -a : a;
    b_mag   = sb ? -b : b;
    // Remainder follows the dividend; everything else follows the sign product.
    res_neg = (op == MD_REM) ? sa : (sa ^ sb);
  end

  always_comb begin
    prod  = res_neg_q ? -raw : raw;
    div_v = res_op[1] ? raw[2*WIDTH-1:WIDTH] : raw[WIDTH-1:0];
    div_s = res_neg_q ? -div_v : div_v;
    if (is_div(res_op))
      res = div_s;
    else if (res_op == MD_MUL)
      res = prod[WIDTH-1:0];
    else
      res = prod[2*WIDTH-1:WIDTH];
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, with valid/ready handshakes and a single-cycle fast path.
module alu_muldiv
  import md_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] bus_a,
  input  logic [WIDTH-1:0] bus_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [TAG_W-1:0] out_tag,
  output logic             alu_zero,
  output logic             alu_neg,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   opnd;
  md_op_e             op_q;
  logic               neg_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               res_neg;
  logic [WIDTH-1:0]   fix_res;
  logic               div_zero;
  logic               div_ovf;
  logic               fast;
  logic [WIDTH-1:0]   fast_res;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;

  md_signfix #(.WIDTH(WIDTH)) u_signfix (
    .op        (op),
    .a         (bus_a),
    .b         (bus_b),
    .a_mag     (a_mag),
    .b_mag     (b_mag),
    .res_neg   (res_neg),
    .res_op    (op_q),
    .res_neg_q (neg_q),
    .raw       (acc_nxt),
    .res       (fix_res)
  );

  // Divide-by-zero and signed overflow resolve without iterating.
  always_comb begin
    div_zero = is_div(op) && (bus_b == '0);
    div_ovf  = ((op == MD_DIV) || (op == MD_REM)) && (bus_a == MIN_VAL) && (bus_b == '1);
    fast     = div_zero || div_ovf;
    if (div_zero)
      fast_res = op[1] ? bus_a : '1;
    else
      fast_res = op[1] ? '0 : MIN_VAL;
  end

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (is_div(op_q)) begin
      if (!div_diff[WIDTH])
        acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_nxt = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_nxt = {add_sum, acc[WIDTH-1:1]};
    end else begin
      acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      alu_out   <= '0;
      out_tag   <= '0;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      op_q      <= MD_MUL;
      neg_q     <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            out_tag  <= in_tag;
            op_q     <= op;
            neg_q    <= res_neg;
            cnt      <= '0;
            opnd     <= is_div(op) ? b_mag : a_mag;
            acc      <= {{WIDTH{1'b0}}, (is_div(op) ? a_mag : b_mag)};
            if (fast) begin
              state     <= DONE;
              out_valid <= 1'b1;
              alu_out   <= fast_res;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH-1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            alu_out   <= fix_res;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_zero = (alu_out == '0);
  assign alu_neg  = alu_out[WIDTH-1];

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized and directed bench for alu_muldiv against an arithmetic reference model.
module tb_alu_muldiv;
  import md_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned TAG_W = 5;
  localparam logic [31:0] MIN32 = 32'h8000_0000;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  md_op_e           op;
  logic [WIDTH-1:0] bus_a;
  logic [WIDTH-1:0] bus_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic [TAG_W-1:0] out_tag;
  logic             alu_zero;
  logic             alu_neg;
  logic             busy;

  int vectors;
  int miscompares;

  alu_muldiv #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .bus_a     (bus_a),
    .bus_b     (bus_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_out   (alu_out),
    .out_tag   (out_tag),
    .alu_zero  (alu_zero),
    .alu_neg   (alu_neg),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference semantics of RV32M, written with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_md(input md_op_e o, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (o)
      MD_MUL:    begin p = 64'(ua * ub); return p[31:0];  end
      MD_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
      MD_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
      MD_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
      MD_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == MIN32 && b == 32'hFFFF_FFFF) return MIN32;
        p = 64'(sa / sb); return p[31:0];
      end
      MD_DIVU: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        return a / b;
      end
      MD_REM: begin
        if (b == 32'h0) return a;
        if (a == MIN32 && b == 32'hFFFF_FFFF) return 32'h0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(input md_op_e o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && b == 32'h0) return 1;
    if ((o == MD_DIV || o == MD_REM) && a == MIN32 && b == 32'hFFFF_FFFF) return 1;
    return WIDTH + 1;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return MIN32;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one op, check latency and result, then hold out_ready low for 'hold' cycles.
  task automatic run_op(input md_op_e o, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] t, input int hold);
    logic [31:0] exp;
    int exp_lat;
    int cyc;
    exp     = ref_md(o, a, b);
    exp_lat = ref_latency(o, a, b);
    @(negedge clk);
    check_eq("in_ready_before", 64'(in_ready), 64'(1));
    in_valid  = 1'b1;
    op        = o;
    bus_a     = a;
    bus_b     = b;
    in_tag    = t;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    op       = md_op_e'(3'($urandom));
    bus_a    = $urandom;
    bus_b    = $urandom;
    in_tag   = TAG_W'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("latency", 64'(cyc), 64'(exp_lat));
    check_eq("alu_out", 64'(alu_out), 64'(exp));
    check_eq("out_tag", 64'(out_tag), 64'(t));
    check_eq("alu_zero", 64'(alu_zero), 64'(exp == 32'h0));
    check_eq("alu_neg", 64'(alu_neg), 64'(exp[31]));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 64'(out_valid), 64'(1));
      check_eq("hold_out", 64'(alu_out), 64'(exp));
      check_eq("hold_ready", 64'(in_ready), 64'(0));
      if (i == hold - 1) out_ready = 1'b1;
    end
    @(negedge clk);
    check_eq("post_valid", 64'(out_valid), 64'(0));
    check_eq("post_ready", 64'(in_ready), 64'(1));
  endtask

  initial begin
    int cyc;
    int seen;
    logic [31:0] held;
    md_op_e ro;
    vectors     = 0;
    miscompares = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    op        = MD_MUL;
    bus_a     = '0;
    bus_b     = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'(1));
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_alu_out", 64'(alu_out), 64'(0));
    check_eq("rst_out_tag", 64'(out_tag), 64'(0));
    check_eq("rst_alu_zero", 64'(alu_zero), 64'(1));
    check_eq("rst_alu_neg", 64'(alu_neg), 64'(0));
    rst = 1'b0;

    // Directed cases
    run_op(MD_MUL,    32'd7,        32'hFFFF_FFFD, 5'd5, 0);
    run_op(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 0);
    run_op(MD_MULH,   MIN32,        MIN32,         5'd2, 0);
    run_op(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 0);
    run_op(MD_DIV,    32'hFFFF_FFF9, 32'd2,         5'd4, 0);
    run_op(MD_REM,    32'hFFFF_FFF9, 32'd2,         5'd6, 0);
    run_op(MD_DIVU,   32'd100,      32'd0,         5'd7, 0);
    run_op(MD_REM,    32'd100,      32'd0,         5'd8, 0);
    run_op(MD_DIV,    MIN32,        32'hFFFF_FFFF, 5'd9, 0);
    run_op(MD_REM,    MIN32,        32'hFFFF_FFFF, 5'd10, 2);

    // Backpressure with a competing request that must be ignored
    @(negedge clk);
    in_valid = 1'b1; op = MD_MULHU; bus_a = 32'hDEAD_BEEF; bus_b = 32'h1234_5678; in_tag = 5'd11;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 100) begin @(negedge clk); cyc++; end
    check_eq("bp_latency", 64'(cyc), 64'(WIDTH + 1));
    check_eq("bp_result", 64'(alu_out), 64'(ref_md(MD_MULHU, 32'hDEAD_BEEF, 32'h1234_5678)));
    held = alu_out;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; op = MD_MUL; bus_a = $urandom; bus_b = $urandom; in_tag = 5'd30;
      @(negedge clk);
      check_eq("bp_stable", 64'(alu_out), 64'(held));
      check_eq("bp_valid", 64'(out_valid), 64'(1));
      check_eq("bp_in_ready", 64'(in_ready), 64'(0));
      check_eq("bp_tag", 64'(out_tag), 64'(11));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_ready", 64'(in_ready), 64'(1));
    check_eq("bp_release_valid", 64'(out_valid), 64'(0));
    check_eq("bp_release_busy", 64'(busy), 64'(0));

    // Flush in cycle 10 of a DIV
    in_valid = 1'b1; op = MD_DIV; bus_a = 32'd1000; bus_b = 32'd7; in_tag = 5'd12;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_ready", 64'(in_ready), 64'(1));
    check_eq("flush_valid", 64'(out_valid), 64'(0));
    check_eq("flush_busy", 64'(busy), 64'(0));
    run_op(MD_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);

    // Flush of a result held in DONE
    @(negedge clk);
    in_valid = 1'b1; op = MD_DIVU; bus_a = 32'd5; bus_b = 32'd0; in_tag = 5'd13; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("done_flush_pre", 64'(out_valid), 64'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1;
    check_eq("done_flush_valid", 64'(out_valid), 64'(0));
    check_eq("done_flush_ready", 64'(in_ready), 64'(1));

    // Flush wins over in_valid in IDLE
    in_valid = 1'b1; flush = 1'b1; op = MD_DIVU; bus_a = 32'd9; bus_b = 32'd0;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check_eq("flush_vs_valid_busy", 64'(busy), 64'(0));
    check_eq("flush_vs_valid_ovalid", 64'(out_valid), 64'(0));

    // Reset mid-CALC, with flush also asserted
    run_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 0);
    in_valid = 1'b1; op = MD_MUL; bus_a = 32'd3; bus_b = 32'd5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1; flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    check_eq("mid_rst_valid", 64'(out_valid), 64'(0));
    check_eq("mid_rst_out", 64'(alu_out), 64'(0));
    check_eq("mid_rst_zero", 64'(alu_zero), 64'(1));
    check_eq("mid_rst_ready", 64'(in_ready), 64'(1));
    check_eq("mid_rst_tag", 64'(out_tag), 64'(0));
    seen = 0;
    repeat (WIDTH + 4) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check_eq("mid_rst_no_result", 64'(seen), 64'(0));

    // Randomized ops with boundary-biased operands and random backpressure
    for (int n = 0; n < 150; n++) begin
      ro = md_op_e'(3'($urandom));
      run_op(ro, pick_operand(), pick_operand(), TAG_W'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
